// File: rtl/store_buffer.sv
// In-order store buffer between the MEM stage and a single-ported data memory.
// Loads win the port unless they hit a pending store or the buffer is full.
module store_buffer #(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  input  logic [2:0]                 st_size,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_addr,
  input  logic [2:0]                 ld_size,
  output logic [31:0]                ld_data,
  output logic                       ld_stall,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wData,
  output logic [2:0]                 mem_size,
  output logic                       mem_wEn,
  input  logic [31:0]                mem_rData,
  output logic [$clog2(SB_DEPTH):0]  sb_count,
  output logic                       sb_empty
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {ModeIdle, ModeLoad, ModeDrain} mode_e;

  logic [31:0]     addr_q [SB_DEPTH];
  logic [31:0]     data_q [SB_DEPTH];
  logic [2:0]      size_q [SB_DEPTH];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;

  logic            full, hazard, size_ok, enq, deq;
  logic [PtrW-1:0] slot;
  logic [32:0]     ld_lo, ld_hi, e_lo, e_hi;
  mode_e           mode;

  // Last byte covered by an access, in 33 bits so spans never wrap.
  function automatic logic [32:0] span_last(input logic [31:0] addr, input logic [2:0] size);
    logic [32:0] ext;
    case (size[1:0])
      2'b00:   ext = 33'd0;
      2'b01:   ext = 33'd1;
      default: ext = 33'd3;
    endcase
    return {1'b0, addr} + ext;
  endfunction

  assign full     = (count_q == CntW'(SB_DEPTH));
  assign st_ready = !full;
  assign sb_count = count_q;
  assign sb_empty = (count_q == '0);
  assign size_ok  = (st_size == 3'b000) || (st_size == 3'b001) || (st_size == 3'b010);
  assign enq      = !rst && st_valid && st_ready && size_ok;
  assign deq      = (mode == ModeDrain);
  assign ld_lo    = {1'b0, ld_addr};
  assign ld_hi    = span_last(ld_addr, ld_size);

  // The same-cycle incoming store is younger than the load, so only stored entries count.
  always_comb begin
    hazard = 1'b0;
    slot   = '0;
    e_lo   = '0;
    e_hi   = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      slot = head_q + PtrW'(i);
      e_lo = {1'b0, addr_q[slot]};
      e_hi = span_last(addr_q[slot], size_q[slot]);
      if ((CntW'(i) < count_q) && (e_lo <= ld_hi) && (ld_lo <= e_hi)) hazard = 1'b1;
    end
    hazard = hazard && ld_valid;
  end

  assign ld_stall = ld_valid && (hazard || full);

  // A full buffer must drain even with a load waiting, else the load could starve.
  always_comb begin
    if (rst)                              mode = ModeIdle;
    else if (ld_valid && !hazard && !full) mode = ModeLoad;
    else if (count_q != '0)               mode = ModeDrain;
    else                                  mode = ModeIdle;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wData = '0;
    mem_size  = 3'b010;
    mem_wEn   = 1'b0;
    ld_data   = '0;
    unique case (mode)
      ModeLoad: begin
        mem_addr = ld_addr;
        mem_size = ld_size;
        ld_data  = mem_rData;
      end
      ModeDrain: begin
        mem_addr  = addr_q[head_q];
        mem_wData = data_q[head_q];
        mem_size  = size_q[head_q];
        mem_wEn   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + PtrW'(1);
      if (deq) head_q <= head_q + PtrW'(1);
      if (enq && !deq)      count_q <= count_q + CntW'(1);
      else if (!enq && deq) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
      size_q[tail_q] <= st_size;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized check of store_buffer against a queue-based model plus directed sequences.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, st_valid, ld_valid, st_ready, ld_stall, mem_wEn, sb_empty;
  logic [31:0] st_addr, st_data, ld_addr, ld_data, mem_addr, mem_wData, mem_rData;
  logic [2:0]  st_size, ld_size, mem_size;
  logic [2:0]  sb_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  s;
  } ent_t;

  ent_t     q[$];
  bit [7:0] env_mem [4096];
  bit [7:0] ref_mem [4096];
  bit       started = 0;
  logic [31:0] env_raw;

  store_buffer #(.SB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_data(ld_data),
    .ld_stall(ld_stall),
    .mem_addr(mem_addr), .mem_wData(mem_wData), .mem_size(mem_size), .mem_wEn(mem_wEn),
    .mem_rData(mem_rData), .sb_count(sb_count), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  function automatic int span_n(input logic [2:0] s);
    return (s[1:0] == 2'b00) ? 1 : (s[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] s);
    case (s)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'd0, raw[7:0]};
      3'b101:  return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic bit overlaps(input logic [31:0] a1, input logic [2:0] s1,
                                  input logic [31:0] a2, input logic [2:0] s2);
    longint lo1 = longint'(a1), lo2 = longint'(a2);
    longint hi1 = lo1 + span_n(s1) - 1, hi2 = lo2 + span_n(s2) - 1;
    return (lo1 <= hi2) && (lo2 <= hi1);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [2:0] s);
    logic [11:0] b = a[11:0];
    logic [31:0] raw = {ref_mem[12'(b + 12'd3)], ref_mem[12'(b + 12'd2)],
                        ref_mem[12'(b + 12'd1)], ref_mem[b]};
    return extend(raw, s);
  endfunction

  // Bench-side data memory: combinational read, byte-granular write at the clock edge.
  assign env_raw = {env_mem[12'(mem_addr[11:0] + 12'd3)], env_mem[12'(mem_addr[11:0] + 12'd2)],
                    env_mem[12'(mem_addr[11:0] + 12'd1)], env_mem[mem_addr[11:0]]};
  assign mem_rData = extend(env_raw, mem_size);

  always @(posedge clk) begin
    if (mem_wEn)
      for (int k = 0; k < span_n(mem_size); k++)
        env_mem[12'(mem_addr[11:0] + 12'(k))] <= mem_wData[8*k +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: queue of pending stores; mode 0 idle, 1 load, 2 drain.
  always @(negedge clk) begin
    bit   full, haz;
    int   mode;
    ent_t e;
    full = (q.size() == DEPTH);
    haz  = 0;
    if (ld_valid) foreach (q[i]) if (overlaps(q[i].a, q[i].s, ld_addr, ld_size)) haz = 1;
    if (rst)                              mode = 0;
    else if (ld_valid && !haz && !full)   mode = 1;
    else if (q.size() > 0)                mode = 2;
    else                                  mode = 0;
    if (started) begin
      chk("st_ready", 32'(st_ready), 32'(!full));
      chk("ld_stall", 32'(ld_stall), 32'(ld_valid && (haz || full)));
      chk("sb_count", 32'(sb_count), 32'(q.size()));
      chk("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
      chk("mem_wEn", 32'(mem_wEn), 32'(mode == 2));
      case (mode)
        1: begin
          chk("mem_addr", mem_addr, ld_addr);
          chk("mem_size", 32'(mem_size), 32'(ld_size));
          chk("ld_data", ld_data, ref_read(ld_addr, ld_size));
        end
        2: begin
          chk("mem_addr", mem_addr, q[0].a);
          chk("mem_wData", mem_wData, q[0].d);
          chk("mem_size", 32'(mem_size), 32'(q[0].s));
          chk("ld_data", ld_data, 32'd0);
        end
        default: begin
          chk("mem_addr", mem_addr, 32'd0);
          chk("mem_wData", mem_wData, 32'd0);
          chk("mem_size", 32'(mem_size), 32'd2);
          chk("ld_data", ld_data, 32'd0);
        end
      endcase
    end
    if (rst) begin
      q.delete();
      started = 1;
    end else if (started) begin
      if (mode == 2) begin
        e = q.pop_front();
        for (int k = 0; k < span_n(e.s); k++) ref_mem[12'(e.a[11:0] + 12'(k))] = e.d[8*k +: 8];
      end
      if (st_valid && !full && (st_size inside {3'b000, 3'b001, 3'b010}))
        q.push_back('{a: st_addr, d: st_data, s: st_size});
    end
  end

  task automatic idle_in();
    st_valid = 0; st_addr = 0; st_data = 0; st_size = 3'b010;
    ld_valid = 0; ld_addr = 0; ld_size = 3'b010;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    st_valid = 1; st_addr = a; st_data = d; st_size = s;
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] s);
    ld_valid = 1; ld_addr = a; ld_size = s;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mism;
    rst = 1;
    idle_in();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state
    to_neg();
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_wEn", 32'(mem_wEn), 32'd0);
    chk("rst_stall", 32'(ld_stall), 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_size", 32'(mem_size), 32'd2);
    to_drive();

    // Single word store drains next cycle
    st(32'h100, 32'h11223344, 3'b010);
    to_neg(); to_drive();
    idle_in();
    to_neg();
    chk("sw_wEn", 32'(mem_wEn), 32'd1);
    chk("sw_addr", mem_addr, 32'h100);
    chk("sw_size", 32'(mem_size), 32'd2);
    chk("sw_data", mem_wData, 32'h11223344);
    to_drive();
    to_neg();
    chk("sw_empty", 32'(sb_empty), 32'd1);
    to_drive();

    // Fill while a non-overlapping load holds the port, then forced drain
    for (int i = 0; i < 4; i++) begin
      st(32'h400 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), 3'b010);
      ld(32'h800, 3'b010);
      to_neg(); to_drive();
    end
    st_valid = 0;
    to_neg();
    chk("full_st_ready", 32'(st_ready), 32'd0);
    chk("full_stall", 32'(ld_stall), 32'd1);
    chk("full_drain_wEn", 32'(mem_wEn), 32'd1);
    chk("full_drain_addr", mem_addr, 32'h400);
    to_drive();
    to_neg();
    chk("full_ld_stall", 32'(ld_stall), 32'd0);
    chk("full_ld_addr", mem_addr, 32'h800);
    to_drive();
    idle_in();
    repeat (4) begin to_neg(); to_drive(); end

    // Byte store hazards a word load covering it
    st(32'h203, 32'h0000_00AB, 3'b000);
    to_neg(); to_drive();
    idle_in();
    ld(32'h200, 3'b010);
    to_neg();
    chk("haz_stall", 32'(ld_stall), 32'd1);
    to_drive();
    to_neg();
    chk("haz_done", 32'(ld_stall), 32'd0);
    chk("haz_byte", 32'(ld_data[31:24]), 32'hAB);
    to_drive();

    // Half store does not block a byte load just past it
    idle_in();
    st(32'h302, 32'h0000_0085, 3'b000);
    to_neg(); to_drive();
    idle_in();
    repeat (2) begin to_neg(); to_drive(); end
    st(32'h300, 32'h0000_BEEF, 3'b001);
    to_neg(); to_drive();
    idle_in();
    ld(32'h302, 3'b000);
    to_neg();
    chk("nohaz_stall", 32'(ld_stall), 32'd0);
    chk("nohaz_data", ld_data, 32'hFFFF_FF85);
    to_drive();
    idle_in();
    to_neg();
    chk("nohaz_drain_wEn", 32'(mem_wEn), 32'd1);
    chk("nohaz_drain_addr", mem_addr, 32'h300);
    chk("nohaz_drain_size", 32'(mem_size), 32'd1);
    to_drive();

    // Reset discards pending stores
    for (int i = 0; i < 3; i++) begin
      st(32'h500 + 32'(4 * i), 32'h5555_0000 + 32'(i + 1), 3'b010);
      ld(32'h800, 3'b010);
      to_neg(); to_drive();
    end
    idle_in();
    rst = 1;
    to_neg();
    chk("rst_pend_wEn", 32'(mem_wEn), 32'd0);
    to_drive();
    rst = 0;
    to_neg();
    chk("rst_pend_count", 32'(sb_count), 32'd0);
    chk("rst_pend_wEn2", 32'(mem_wEn), 32'd0);
    to_drive();
    repeat (3) begin to_neg(); to_drive(); end
    chk("rst_discard", 32'(env_mem[12'h500]), 32'd0);

    // Unsupported store size is dropped
    st(32'h600, 32'hDEAD_BEEF, 3'b100);
    to_neg(); to_drive();
    idle_in();
    to_neg();
    chk("bad_size_count", 32'(sb_count), 32'd0);
    chk("bad_size_wEn", 32'(mem_wEn), 32'd0);
    to_drive();

    // Random traffic in a small window to provoke hazards and wrap the pointers
    repeat (3000) begin
      rst      = ($urandom_range(0, 199) == 0);
      st_valid = $urandom_range(0, 1);
      st_addr  = 32'h100 + 32'($urandom_range(0, 31));
      st_data  = $urandom;
      case ($urandom_range(0, 9))
        0:       st_size = 3'b011;
        1:       st_size = 3'b100;
        2, 3, 4: st_size = 3'b000;
        5, 6:    st_size = 3'b001;
        default: st_size = 3'b010;
      endcase
      ld_valid = $urandom_range(0, 1);
      ld_addr  = 32'h100 + 32'($urandom_range(0, 31));
      case ($urandom_range(0, 4))
        0:       ld_size = 3'b000;
        1:       ld_size = 3'b001;
        2:       ld_size = 3'b010;
        3:       ld_size = 3'b100;
        default: ld_size = 3'b101;
      endcase
      to_neg(); to_drive();
    end
    rst = 0;
    idle_in();
    repeat (8) begin to_neg(); to_drive(); end

    mism = 0;
    for (int i = 0; i < 4096; i++) if (env_mem[i] != ref_mem[i]) mism++;
    chk("mem_image", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: SB_DEPTH, default 4, number of pending-store entries; power of two, >= 2.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 st_valid  input  1  MEM stage presents a store this cycle.
REQ-005 st_addr  input  32  store byte address.
REQ-006 st_data  input  32  store data, LSB-aligned.
REQ-007 st_size  input  3  funct3: 000 byte, 001 half, 010 word.
REQ-008 st_ready  output  1  entry free; store accepted when st_valid && st_ready.
REQ-009 ld_valid  input  1  MEM stage presents a load this cycle.
REQ-010 ld_addr  input  32  load byte address.
REQ-011 ld_size  input  3  funct3: 000, 001, 010, 100, 101.
REQ-012 ld_data  output  32  load result, combinational from mem_rData.
REQ-013 ld_stall  output  1  load cannot complete this cycle; MEM stage holds the load.
REQ-014 mem_addr  output  32  address to data memory.
REQ-015 mem_wData  output  32  write data to data memory.
REQ-016 mem_size  output  3  funct3 to data memory.
REQ-017 mem_wEn  output  1  write enable to data memory.
REQ-018 mem_rData  input  32  combinational read data from data memory.
REQ-019 sb_count  output  $clog2(SB_DEPTH)+1  valid entries; sb_empty output 1, high when sb_count==0.

Function
REQ-020 Circular FIFO: head/tail pointers and count; entry = {addr, data, size}.
REQ-021 st_ready SHALL be (sb_count < SB_DEPTH), independent of same-cycle dequeue.
REQ-022 Accepted store with st_size not in {000, 001, 010}: dropped, no entry written, count unchanged.
REQ-023 Byte span of an access: size[1:0] 00 -> 1, 01 -> 2, 10 -> 4 bytes; span [addr, addr+n-1] in 33-bit arithmetic, no wrap.
REQ-024 hazard = ld_valid && any valid entry's span intersects the load span; the same-cycle incoming store is excluded, the load being older.
REQ-025 Port mode LOAD when ld_valid && !hazard && sb_count < SB_DEPTH: mem_addr=ld_addr, mem_size=ld_size, mem_wEn=0, ld_data=mem_rData, ld_stall=0.
REQ-026 Port mode DRAIN when not LOAD and sb_count > 0: mem_addr/mem_wData/mem_size from head entry, mem_wEn=1; head advances and entry retires at the clock edge.
REQ-027 Port mode IDLE otherwise: mem_addr=0, mem_wData=0, mem_size=3'b010, mem_wEn=0.
REQ-028 ld_stall = ld_valid && (hazard || sb_count == SB_DEPTH); a full buffer forces DRAIN, preventing load starvation.
REQ-029 ld_data = 0 whenever ld_valid=0 or ld_stall=1.
REQ-030 Enqueue and dequeue in the same cycle: count unchanged, both pointers advance modulo SB_DEPTH.
REQ-031 Entries drain strictly in acceptance order; at most one drain per cycle.
REQ-032 Latency: a store accepted in cycle N is written to memory no earlier than cycle N+1.
REQ-033 A stalled load re-evaluates each cycle; it completes in the first cycle with no hazard and a non-full buffer.

Reset
REQ-034 With rst high at posedge clk: head=0, tail=0, sb_count=0, all entries invalid; pending stores discarded, including mid-drain.
REQ-035 While rst is high, st_valid and ld_valid are ignored for state update.
REQ-036 Outputs after reset: st_ready=1, sb_empty=1, mem_wEn=0, ld_stall=0 (absent ld_valid), ld_data=0, mem_addr=0, mem_size=3'b010.

Verification
REQ-037 Sequence: store word 0x11223344 @0x100 -> mem_wEn=1, addr 0x100, size 010 in the next cycle; sb_empty=1 afterwards.
REQ-038 Sequence: 4 stores with no drain opportunity, ld_valid held to non-overlapping 0x800 -> after 4th store st_ready=0 and ld_stall=1, forced drain of entry 0, then the load completes.
REQ-039 Sequence: store byte 0xAB @0x203 pending, then lw @0x200 -> ld_stall=1 until the entry drains; next cycle ld_data[31:24]=0xAB.
REQ-040 Sequence: store half @0x300 pending, then lb @0x302 -> no stall, ld_data from memory immediately; the store drains afterwards.
REQ-041 Sequence: rst asserted with 3 entries pending -> next cycle sb_count=0, mem_wEn=0, and no pending write reaches memory.
REQ-042 Sequence: st_valid with st_size=3'b100 -> no entry created; sb_count unchanged.
